// File: rtl/pdm_mic_capture.sv
// PDM microphone front end: bit-clock generation, 1-bit capture, decimation to PCM,
// and a one-entry ready/valid output with frame marking. Define PDM_CIC2_EN for the CIC2 decimator.
module pdm_mic_capture #(
   parameter int CLK_DIV      = 32,
   parameter int DECIMATION   = 64,
   parameter int SAMPLE_WIDTH = 16,
   parameter int FRAME_LEN    = 512
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    enable_in,
   input  logic                    mic_data_in,
   output logic                    mic_clk_out,
   output logic [SAMPLE_WIDTH-1:0] sample_out,
   output logic                    sample_valid_out,
   output logic                    sample_last_out,
   input  logic                    sample_ready_in,
   output logic                    overflow_out
);

   localparam int LD = $clog2(DECIMATION);
   localparam int CW = $clog2(CLK_DIV);
   localparam int FW = $clog2(FRAME_LEN);
   localparam logic [SAMPLE_WIDTH-1:0] S_MAX = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};

`ifdef PDM_CIC2_EN
   localparam int VW   = 2*LD + 2;
   localparam int SH   = SAMPLE_WIDTH - 1 - 2*LD;
   localparam int FULL = DECIMATION * DECIMATION;
`else
   localparam int VW   = LD + 2;
   localparam int SH   = SAMPLE_WIDTH - 1 - LD;
   localparam int FULL = DECIMATION;
`endif

   // Full-scale positive has no exact PCM code, so it clips; full-scale negative maps exactly.
   function automatic logic [SAMPLE_WIDTH-1:0] scale_out(input logic signed [VW-1:0] s);
      logic signed [SAMPLE_WIDTH+VW-1:0] w;
      w = {{SAMPLE_WIDTH{s[VW-1]}}, s};
      w = w <<< SH;
      if (s == VW'(FULL))
         return S_MAX;
      return w[SAMPLE_WIDTH-1:0];
   endfunction

   logic [CW-1:0] cnt;
   logic          mic_prev;
   logic          tick;

   always_ff @(posedge clk_in) begin
      if (rst_in || !enable_in) begin
         cnt         <= '0;
         mic_clk_out <= 1'b0;
         mic_prev    <= 1'b0;
      end else begin
         cnt         <= (cnt == CW'(CLK_DIV-1)) ? '0 : cnt + 1'b1;
         mic_clk_out <= (cnt < CW'(CLK_DIV/2));
         mic_prev    <= mic_clk_out;
      end
   end

   assign tick = mic_clk_out && !mic_prev;

   logic [LD-1:0]           phase;
   logic                    last_phase;
   logic signed [VW-1:0]    step;
   logic                    dec_vld;
   logic [SAMPLE_WIDTH-1:0] dec_val;

   assign last_phase = (phase == LD'(DECIMATION-1));
   assign step       = mic_data_in ? VW'(1) : '1;

`ifdef PDM_CIC2_EN
   logic signed [VW-1:0] i1, i2, i1_next, i2_next, z1, z2, c1, y;
   logic [1:0]           warm;

   assign i1_next = i1 + step;
   assign i2_next = i2 + i1_next;
   assign c1      = i2_next - z1;
   assign y       = c1 - z2;

   // Combs are not primed until two decimated outputs have passed through them.
   always_ff @(posedge clk_in) begin
      if (rst_in || !enable_in) begin
         i1      <= '0;
         i2      <= '0;
         z1      <= '0;
         z2      <= '0;
         phase   <= '0;
         warm    <= '0;
         dec_vld <= 1'b0;
         dec_val <= '0;
      end else begin
         dec_vld <= 1'b0;
         if (tick) begin
            i1    <= i1_next;
            i2    <= i2_next;
            phase <= phase + 1'b1;
            if (last_phase) begin
               z1 <= i2_next;
               z2 <= c1;
               if (warm == 2'd2) begin
                  dec_vld <= 1'b1;
                  dec_val <= scale_out(y);
               end else begin
                  warm <= warm + 1'b1;
               end
            end
         end
      end
   end
`else
   logic signed [VW-1:0] acc, acc_next;

   assign acc_next = acc + step;

   always_ff @(posedge clk_in) begin
      if (rst_in || !enable_in) begin
         acc   <= '0;
         phase <= '0;
      end else if (tick) begin
         phase <= phase + 1'b1;
         acc   <= last_phase ? '0 : acc_next;
      end
   end

   // The D-th bit is folded in combinationally so the sample lands on that tick's edge.
   assign dec_vld = enable_in && tick && last_phase;
   assign dec_val = scale_out(acc_next);
`endif

   logic          xfer;
   logic          valid_next;
   logic [FW-1:0] fcnt, fcnt_next;

   assign xfer = sample_valid_out && sample_ready_in;

   always_comb begin
      fcnt_next = fcnt;
      if (xfer)
         fcnt_next = (fcnt == FW'(FRAME_LEN-1)) ? '0 : fcnt + 1'b1;
      valid_next = sample_valid_out;
      if (dec_vld && (!sample_valid_out || xfer))
         valid_next = 1'b1;
      else if (xfer)
         valid_next = 1'b0;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         fcnt             <= '0;
         sample_out       <= '0;
         sample_valid_out <= 1'b0;
         sample_last_out  <= 1'b0;
         overflow_out     <= 1'b0;
      end else begin
         fcnt             <= fcnt_next;
         sample_valid_out <= valid_next;
         sample_last_out  <= valid_next && (fcnt_next == FW'(FRAME_LEN-1));
         if (dec_vld) begin
            if (!sample_valid_out || xfer)
               sample_out <= dec_val;
            else
               overflow_out <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pdm_mic_capture.sv
// Bench for pdm_mic_capture (first-order build) with a reduced configuration:
// a behavioural model checked every cycle plus directed literal expectations.
module tb_pdm_mic_capture;

   localparam int CD = 4;
   localparam int D  = 8;
   localparam int LD = 3;
   localparam int SW = 16;
   localparam int FL = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, enable, mic_data, ready;
   logic mic_clk, valid, last, ovf;
   logic [SW-1:0] sample;

   pdm_mic_capture #(.CLK_DIV(CD), .DECIMATION(D), .SAMPLE_WIDTH(SW), .FRAME_LEN(FL)) dut (
      .clk_in(clk), .rst_in(rst), .enable_in(enable), .mic_data_in(mic_data),
      .mic_clk_out(mic_clk), .sample_out(sample), .sample_valid_out(valid),
      .sample_last_out(last), .sample_ready_in(ready), .overflow_out(ovf)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit cmp_on = 1'b0;
   int dmode = 1;   // 0 const0, 1 const1, 2 alternate per tick, 3 random
   int rmode = 1;   // 0 low, 1 high, 2 random
   bit tb_prev = 1'b0;

   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
      end
   endtask

   function automatic logic [SW-1:0] mscale(input int sum);
      int v;
      if (sum == D) return 16'h7FFF;
      v = sum * (1 << (SW-1-LD));
      return v[SW-1:0];
   endfunction

   // Behavioural model: counts enabled cycles, collects D tick bits, then applies output rules.
   int m_n = 0, m_ticks = 0, m_ones = 0, m_fcnt = 0;
   bit m_valid = 0, m_ovf = 0, m_clk = 0;
   logic [SW-1:0] m_sample = '0;

   always @(posedge clk) begin
      bit x, prod;
      logic [SW-1:0] v;
      cyc++;
      v = '0;
      if (rst) begin
         m_n = 0; m_ticks = 0; m_ones = 0; m_fcnt = 0;
         m_valid = 0; m_ovf = 0; m_clk = 0; m_sample = '0;
      end else begin
         x = m_valid && ready;
         prod = 0;
         if (!enable) begin
            m_n = 0; m_ticks = 0; m_ones = 0;
         end else begin
            if (m_n % CD == 1) begin
               m_ticks++;
               m_ones += int'(mic_data);
               if (m_ticks == D) begin
                  prod = 1;
                  v = mscale(2*m_ones - D);
                  m_ticks = 0; m_ones = 0;
               end
            end
            m_n++;
         end
         if (x) m_fcnt = (m_fcnt + 1) % FL;
         if (prod) begin
            if (!m_valid || x) begin m_sample = v; m_valid = 1; end
            else m_ovf = 1;
         end else if (x) m_valid = 0;
         m_clk = enable && (((m_n - 1) % CD) < CD/2);
      end
   end

   always @(negedge clk) begin
      if (cmp_on) begin
         check("mic_clk", int'(mic_clk), int'(m_clk));
         check("valid", int'(valid), int'(m_valid));
         check("overflow", int'(ovf), int'(m_ovf));
         check("last", int'(last), int'(m_valid && m_fcnt == FL-1));
         if (m_valid) check("sample", int'(sample), int'(m_sample));
      end
   end

   // Input driver, updated just after each active edge.
   always @(posedge clk) begin
      #1;
      case (dmode)
         0: mic_data = 1'b0;
         1: mic_data = 1'b1;
         2: if (mic_clk && !tb_prev) mic_data = ~mic_data;
         default: mic_data = 1'($urandom % 2);
      endcase
      tb_prev = mic_clk;
      case (rmode)
         0: ready = 1'b0;
         1: ready = 1'b1;
         default: ready = 1'($urandom % 2);
      endcase
   end

   task automatic wait_xfer(input string nm, output logic [SW-1:0] v, output bit lst, output int t);
      bit got = 0;
      v = '0; lst = 0; t = 0;
      for (int k = 0; k < 4*D*CD && !got; k++) begin
         @(negedge clk);
         if (valid && ready) begin
            got = 1; v = sample; lst = last; t = cyc;
         end
      end
      if (!got) begin
         total++; bad++;
         $display("FAIL %s: no transfer within %0d cycles", nm, 4*D*CD);
      end
   endtask

   task automatic rst_pulse();
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
   endtask

   initial begin
      logic [SW-1:0] v, held;
      bit lst, got;
      int t0, t1, hi, rises, nvalid, idx, l1, l2, nlast, mism;
      bit pc;
      rst = 1'b1; enable = 1'b0; mic_data = 1'b0; ready = 1'b1;
      repeat (3) @(negedge clk);
      cmp_on = 1'b1;
      check("rst_valid", int'(valid), 0);
      check("rst_sample", int'(sample), 0);
      check("rst_last", int'(last), 0);
      check("rst_ovf", int'(ovf), 0);
      check("rst_mic_clk", int'(mic_clk), 0);

      rst = 1'b0;
      hi = 0; nvalid = 0;
      repeat (3*D*CD) begin
         @(negedge clk);
         hi += int'(mic_clk); nvalid += int'(valid);
      end
      check("disabled_mic_clk_high", hi, 0);
      check("disabled_valids", nvalid, 0);

      dmode = 1; rmode = 1;
      enable = 1'b1;
      hi = 0; rises = 0; pc = 0;
      repeat (10*CD) begin
         @(negedge clk);
         hi += int'(mic_clk);
         rises += int'(mic_clk && !pc);
         pc = mic_clk;
      end
      check("mic_clk_high_cycles", hi, 10*CD/2);
      check("mic_clk_periods", rises, 10);

      wait_xfer("const1_a", v, lst, t0);
      check("const1_a", int'(v), 32'h7FFF);
      wait_xfer("const1_b", v, lst, t1);
      check("const1_b", int'(v), 32'h7FFF);
      check("sample_period", t1 - t0, D*CD);

      dmode = 0;
      wait_xfer("skip0", v, lst, t0);
      wait_xfer("const0_a", v, lst, t0);
      check("const0_a", int'(v), 32'h8000);
      wait_xfer("const0_b", v, lst, t0);
      check("const0_b", int'(v), 32'h8000);

      dmode = 2;
      wait_xfer("skipalt", v, lst, t0);
      wait_xfer("alt_a", v, lst, t0);
      check("alt_a", int'(v), 0);
      wait_xfer("alt_b", v, lst, t0);
      check("alt_b", int'(v), 0);

      // Frame marking over two frames from a clean reset.
      dmode = 3;
      rst_pulse();
      l1 = -1; l2 = -1; nlast = 0;
      for (int n = 1; n <= 2*FL + 2; n++) begin
         wait_xfer("frame", v, lst, t0);
         if (lst) begin
            nlast++;
            if (l1 < 0) l1 = n; else if (l2 < 0) l2 = n;
         end
      end
      check("first_last_index", l1, FL);
      check("second_last_index", l2, 2*FL);
      check("last_count", nlast, 2);
      check("no_overflow", int'(ovf), 0);

      // Backpressure: first sample held, later ones dropped.
      rmode = 0;
      repeat (2) @(negedge clk);
      got = 0;
      for (int k = 0; k < 4*D*CD && !got; k++) begin
         @(negedge clk);
         if (valid) got = 1;
      end
      check("bp_valid_seen", int'(got), 1);
      held = sample;
      check("bp_ovf_first", int'(ovf), 0);
      mism = 0;
      repeat (3*D*CD) begin
         @(negedge clk);
         if (!valid || sample != held) mism++;
      end
      check("bp_held_stable", mism, 0);
      check("bp_ovf_set", int'(ovf), 1);
      rmode = 1;
      wait_xfer("bp_release", v, lst, t0);
      check("bp_release_value", int'(v), int'(held));
      check("bp_ovf_sticky", int'(ovf), 1);

      // Reset mid-frame.
      rst_pulse();
      for (int n = 0; n < 10; n++) wait_xfer("pre_rst", v, lst, t0);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_valid", int'(valid), 0);
      check("midrst_sample", int'(sample), 0);
      check("midrst_last", int'(last), 0);
      check("midrst_ovf", int'(ovf), 0);
      check("midrst_mic_clk", int'(mic_clk), 0);
      rst = 1'b0;
      idx = -1;
      for (int n = 1; n <= FL + 2 && idx < 0; n++) begin
         wait_xfer("post_rst", v, lst, t0);
         if (lst) idx = n;
      end
      check("post_rst_last_index", idx, FL);

      // Random data, ready and enable, checked by the model.
      rmode = 2;
      rst_pulse();
      repeat (4000) begin
         @(negedge clk);
         if ($urandom_range(0, 149) == 0) enable = ~enable;
         if ($urandom_range(0, 1999) == 0) rst = 1'b1; else rst = 1'b0;
      end
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
